// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline stage: parametrised payload register with valid/ready flow control,
// synchronous flush, bubble squashing and an optional two-entry skid buffer.
module ex_mem_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_W-1:0]  in_wreg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [REG_W-1:0]  out_wreg,
  output logic [1:0]        occupancy,
  output logic [1:0]        dbgState
);

  localparam int PW = CTRL_W + 2 * DATA_W + REG_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stateT;

  stateT         state, nextState;
  logic [PW-1:0] mainQ, skidQ, mainNext, skidNext, inPkt;
  logic          readyQ, accept, pop, outValid;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and payload is don't-care while valid is low.
  assign inPkt    = {in_ctrl, in_alu, in_wdata, in_wreg};
  assign outValid = (state != EMPTY);
  assign in_ready = (SKID != 0) ? readyQ : (!outValid || out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = outValid && out_ready;

  // With SKID=0 in_ready forces accept-in-ONE to coincide with pop, so FULL is unreachable.
  always_comb begin
    nextState = state;
    mainNext  = mainQ;
    skidNext  = skidQ;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            nextState = ONE;
            mainNext  = inPkt;
          end
        end
        ONE: begin
          if (accept && pop) begin
            mainNext = inPkt;
          end else if (accept) begin
            nextState = FULL;
            skidNext  = inPkt;
          end else if (pop) begin
            nextState = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            nextState = ONE;
            mainNext  = skidQ;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      mainQ  <= '0;
      skidQ  <= '0;
      readyQ <= 1'b0;
    end else begin
      state  <= nextState;
      mainQ  <= mainNext;
      skidQ  <= skidNext;
      readyQ <= (nextState != FULL);
    end
  end

  assign out_valid = outValid;
  assign out_ctrl  = outValid ? mainQ[PW-1 -: CTRL_W] : '0;
  assign out_alu   = mainQ[PW-CTRL_W-1 -: DATA_W];
  assign out_wdata = mainQ[REG_W +: DATA_W];
  assign out_wreg  = mainQ[REG_W-1:0];
  assign dbgState  = state;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench for ex_mem_pipe_stage: a skid (SKID=1) and a flat (SKID=0) instance share
// stimulus; a queue model predicts both every cycle, plus hand-computed literal checks.
module tb_ex_mem_pipe_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int PW = CW + 2 * DW + RW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_alu, in_wdata;
  logic [RW-1:0] in_wreg;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [DW-1:0] out_alu1, out_wdata1, out_alu0, out_wdata0;
  logic [RW-1:0] out_wreg1, out_wreg0;
  logic [1:0]    occ1, occ0, dbg1, dbg0;

  int total = 0;
  int bad = 0;

  ex_mem_pipe_stage #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW), .SKID(1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_wdata(in_wdata), .in_wreg(in_wreg),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_alu(out_alu1), .out_wdata(out_wdata1), .out_wreg(out_wreg1),
    .occupancy(occ1), .dbgState(dbg1)
  );

  ex_mem_pipe_stage #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW), .SKID(0)) u_flat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_wdata(in_wdata), .in_wreg(in_wreg),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_alu(out_alu0), .out_wdata(out_wdata0), .out_wreg(out_wreg0),
    .occupancy(occ0), .dbgState(dbg0)
  );

  // Reference model: a FIFO per instance, capacity 2 (skid) or 1 (flat).
  logic [PW-1:0] q1[$];
  logic [PW-1:0] q0[$];
  logic [PW-1:0] last1 = '0;
  logic [PW-1:0] last0 = '0;
  logic          rdy1 = 1'b0;
  logic [PW-1:0] inPkt;
  assign inPkt = {in_ctrl, in_alu, in_wdata, in_wreg};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1.delete();
      q0.delete();
      last1 = '0;
      last0 = '0;
      rdy1  = 1'b0;
    end else begin
      logic acc1, pop1, acc0, pop0;
      acc1 = in_valid && rdy1;
      pop1 = (q1.size() > 0) && out_ready;
      acc0 = in_valid && ((q0.size() == 0) || out_ready);
      pop0 = (q0.size() > 0) && out_ready;
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (pop1) void'(q1.pop_front());
        if (acc1) q1.push_back(inPkt);
        if (pop0) void'(q0.pop_front());
        if (acc0) q0.push_back(inPkt);
      end
      if (q1.size() > 0) last1 = q1[0];
      if (q0.size() > 0) last0 = q0[0];
      rdy1 = (q1.size() < 2);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmpDut(input string tag, input int size, input logic [PW-1:0] head,
                        input logic expRdy, input logic actRdy, input logic actValid,
                        input logic [CW-1:0] actCtrl, input logic [DW-1:0] actAlu,
                        input logic [DW-1:0] actWdata, input logic [RW-1:0] actWreg,
                        input logic [1:0] actOcc);
    logic [CW-1:0] expCtrl;
    expCtrl = (size > 0) ? head[PW-1 -: CW] : '0;
    chk({tag, ".in_ready"}, 64'(actRdy), 64'(expRdy));
    chk({tag, ".out_valid"}, 64'(actValid), 64'(size > 0));
    chk({tag, ".out_ctrl"}, 64'(actCtrl), 64'(expCtrl));
    chk({tag, ".out_alu"}, 64'(actAlu), 64'(head[PW-CW-1 -: DW]));
    chk({tag, ".out_wdata"}, 64'(actWdata), 64'(head[RW +: DW]));
    chk({tag, ".out_wreg"}, 64'(actWreg), 64'(head[RW-1:0]));
    chk({tag, ".occupancy"}, 64'(actOcc), 64'(size));
  endtask

  always @(negedge clk) begin
    logic [PW-1:0] h1, h0;
    h1 = (q1.size() > 0) ? q1[0] : last1;
    h0 = (q0.size() > 0) ? q0[0] : last0;
    cmpDut("skid", q1.size(), h1, rdy1, in_ready1, out_valid1, out_ctrl1, out_alu1,
           out_wdata1, out_wreg1, occ1);
    cmpDut("flat", q0.size(), h0, (q0.size() == 0) || out_ready, in_ready0, out_valid0,
           out_ctrl0, out_alu0, out_wdata0, out_wreg0, occ0);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one entry and holds it until the skid instance takes it.
  task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] a,
                       input logic [DW-1:0] w, input logic [RW-1:0] r);
    bit took;
    int n;
    in_valid = 1'b1;
    in_ctrl  = c;
    in_alu   = a;
    in_wdata = w;
    in_wreg  = r;
    took = 1'b0;
    n = 0;
    while (!took && n < 20) begin
      @(negedge clk);
      took = rdy1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!took) begin
      total++;
      bad++;
      $display("FAIL offer_timeout alu=%0h not accepted within 20 cycles", a);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ctrl = '0; in_alu = '0; in_wdata = '0; in_wreg = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset.out_valid", 64'(out_valid1), 64'd0);
    chk("reset.out_ctrl", 64'(out_ctrl1), 64'd0);
    chk("reset.out_alu", 64'(out_alu1), 64'd0);
    chk("reset.out_wdata", 64'(out_wdata1), 64'd0);
    chk("reset.out_wreg", 64'(out_wreg1), 64'd0);
    chk("reset.occupancy", 64'(occ1), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1);
    chk("release.in_ready", 64'(in_ready1), 64'd1);

    // Single transfer, then bubble.
    offer(4'b0001, 32'h0000_1234, 32'h0, 5'd8);
    chk("t1.out_valid", 64'(out_valid1), 64'd1);
    chk("t1.out_ctrl", 64'(out_ctrl1), 64'h1);
    chk("t1.out_alu", 64'(out_alu1), 64'h1234);
    chk("t1.out_wreg", 64'(out_wreg1), 64'd8);
    chk("t1.flat_alu", 64'(out_alu0), 64'h1234);
    cyc(1);
    chk("t1.bubble_valid", 64'(out_valid1), 64'd0);
    chk("t1.bubble_ctrl", 64'(out_ctrl1), 64'd0);
    chk("t1.hold_alu", 64'(out_alu1), 64'h1234);

    // Back-to-back streaming.
    for (int k = 1; k <= 4; k++) begin
      offer(4'b0001, DW'(k), DW'(k * 16), RW'(k));
      chk("stream.alu", 64'(out_alu1), 64'(k));
      chk("stream.occ", 64'(occ1), 64'd1);
      chk("stream.in_ready", 64'(in_ready1), 64'd1);
    end
    cyc(2);

    // Stall fills the skid buffer; C waits until MEM drains.
    out_ready = 1'b0;
    offer(4'b0011, 32'hA, 32'h0, 5'd1);
    chk("stall.occ_a", 64'(occ1), 64'd1);
    offer(4'b0011, 32'hB, 32'h0, 5'd2);
    chk("stall.occ_b", 64'(occ1), 64'd2);
    chk("stall.in_ready", 64'(in_ready1), 64'd0);
    in_valid = 1'b1; in_ctrl = 4'b0011; in_alu = 32'hC; in_wdata = 32'h0; in_wreg = 5'd3;
    cyc(2);
    chk("stall.hold_ready", 64'(in_ready1), 64'd0);
    chk("stall.head_a", 64'(out_alu1), 64'hA);
    out_ready = 1'b1;
    offer(4'b0011, 32'hC, 32'h0, 5'd3);
    chk("stall.head_c", 64'(out_alu1), 64'hC);
    chk("stall.occ_c", 64'(occ1), 64'd1);
    cyc(2);

    // Flush while FULL with a store presented.
    out_ready = 1'b0;
    offer(4'b0001, 32'hD1, 32'h0, 5'd4);
    offer(4'b0001, 32'hE1, 32'h0, 5'd5);
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 4'b1000;
    in_alu = 32'hF00D; in_wdata = 32'hBEEF; in_wreg = 5'd3;
    cyc(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.out_valid", 64'(out_valid1), 64'd0);
    chk("flush.out_ctrl", 64'(out_ctrl1), 64'd0);
    chk("flush.occ", 64'(occ1), 64'd0);
    chk("flush.in_ready", 64'(in_ready1), 64'd1);
    chk("flush.flat_occ", 64'(occ0), 64'd0);
    out_ready = 1'b1;
    cyc(3);

    // Flush discards an entry accepted in the same cycle.
    out_ready = 1'b0;
    offer(4'b0001, 32'h31, 32'h0, 5'd6);
    flush = 1'b1; in_valid = 1'b1; in_alu = 32'h32;
    cyc(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1.occ", 64'(occ1), 64'd0);
    chk("flush1.out_valid", 64'(out_valid1), 64'd0);
    out_ready = 1'b1;
    cyc(2);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    offer(4'b0001, 32'h11, 32'h0, 5'd7);
    offer(4'b0001, 32'h22, 32'h0, 5'd7);
    chk("areset.pre_occ", 64'(occ1), 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("areset.out_valid", 64'(out_valid1), 64'd0);
    chk("areset.occ", 64'(occ1), 64'd0);
    chk("areset.out_alu", 64'(out_alu1), 64'd0);
    chk("areset.out_ctrl", 64'(out_ctrl1), 64'd0);
    chk("areset.out_wreg", 64'(out_wreg1), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    chk("areset.ready", 64'(in_ready1), 64'd1);
    offer(4'b0001, 32'h77, 32'h78, 5'd9);
    chk("areset.first_alu", 64'(out_alu1), 64'h77);
    chk("areset.first_wreg", 64'(out_wreg1), 64'd9);
    chk("areset.first_valid", 64'(out_valid1), 64'd1);
    cyc(2);

    // Flat instance: combinational ready and in-place replacement.
    out_ready = 1'b0;
    offer(4'b0001, 32'h55, 32'h0, 5'd10);
    chk("flat.stall_ready", 64'(in_ready0), 64'd0);
    chk("flat.stall_valid", 64'(out_valid0), 64'd1);
    out_ready = 1'b1;
    #1;
    chk("flat.comb_ready", 64'(in_ready0), 64'd1);
    offer(4'b0001, 32'h66, 32'h0, 5'd11);
    chk("flat.replace_occ", 64'(occ0), 64'd1);
    chk("flat.replace_alu", 64'(out_alu0), 64'h66);
    chk("flat.replace_valid", 64'(out_valid0), 64'd1);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
